// File: rtl/transaction_dispatcher.sv
// Issuing side of the per-queue scheduler: pops the granted queue head, sends it
// downstream, waits for its completion (or a timeout) and pulses update once.
module transaction_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int SELECTION_WIDTH  = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       valid,
    input  logic [SELECTION_WIDTH-1:0]                 selection,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] queue_heads,
    output logic [NUMBER_OF_QUEUES-1:0]                pop,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [DATA_WIDTH-1:0]                      m_data,
    output logic [SELECTION_WIDTH-1:0]                 m_id,
    input  logic                                       resp_valid,
    output logic                                       update,
    output logic                                       busy,
    output logic                                       timeout_error
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, UPDATE} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] wait_count;
    logic        grant_ok;

    assign grant_ok = valid && (32'(selection) < 32'(NUMBER_OF_QUEUES));
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pop           <= '0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_id          <= '0;
            update        <= 1'b0;
            timeout_error <= 1'b0;
            wait_count    <= '0;
        end else begin
            pop    <= '0;
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        m_id           <= selection;
                        m_data         <= queue_heads[selection];
                        pop[selection] <= 1'b1;
                        m_valid        <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        wait_count <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle wins over the timeout.
                    if (resp_valid) begin
                        update <= 1'b1;
                        state  <= UPDATE;
                    end else if (wait_count == TIMEOUT_LAST) begin
                        wait_count    <= wait_count + 16'd1;
                        timeout_error <= 1'b1;
                        update        <= 1'b1;
                        state         <= UPDATE;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                UPDATE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transaction_dispatcher.sv
// Directed bench for transaction_dispatcher: a per-cycle vector table plus
// hand-written streaming, reset-abort and out-of-range grant sequences.
module tb_transaction_dispatcher;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic [1:0]       selection = '0;
    logic [3:0][31:0] heads;
    logic [3:0]       pop;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [31:0]      m_data;
    logic [1:0]       m_id;
    logic             resp_valid = 1'b0;
    logic             update;
    logic             busy;
    logic             timeout_error;

    logic             valid3 = 1'b0;
    logic [1:0]       selection3 = '0;
    logic [2:0][31:0] heads3;
    logic [2:0]       pop3;
    logic             m_valid3;
    logic [31:0]      m_data3;
    logic [1:0]       m_id3;
    logic             update3;
    logic             busy3;
    logic             timeout_error3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    transaction_dispatcher #(
        .NUMBER_OF_QUEUES(4),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .valid(valid), .selection(selection),
        .queue_heads(heads), .pop(pop), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_id(m_id), .resp_valid(resp_valid), .update(update),
        .busy(busy), .timeout_error(timeout_error)
    );

    transaction_dispatcher #(
        .NUMBER_OF_QUEUES(3),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut3 (
        .clock(clock), .reset(reset), .valid(valid3), .selection(selection3),
        .queue_heads(heads3), .pop(pop3), .m_valid(m_valid3), .m_ready(1'b1),
        .m_data(m_data3), .m_id(m_id3), .resp_valid(1'b1), .update(update3),
        .busy(busy3), .timeout_error(timeout_error3)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        rdy;
        logic        resp;
        logic [3:0]  pop;
        logic        mv;
        logic [31:0] data;
        logic [1:0]  id;
        logic        upd;
        logic        busy;
        logic        to;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] s, input logic r, input logic rv,
                       input logic [3:0] p, input logic mv, input logic [31:0] d,
                       input logic [1:0] id, input logic u, input logic b, input logic t);
        vec_t e;
        e.v = v; e.sel = s; e.rdy = r; e.resp = rv;
        e.pop = p; e.mv = mv; e.data = d; e.id = id; e.upd = u; e.busy = b; e.to = t;
        vq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        e;
        logic [1:0]  sel_hist[16];
        logic        prev_upd;
        logic        seen;
        logic [31:0] D0, D2, D3;

        for (int q = 0; q < 4; q++) heads[q] = 32'hA5A5_0000 + 32'(q);
        for (int q = 0; q < 3; q++) heads3[q] = 32'h3C3C_0000 + 32'(q);
        D0 = 32'hA5A5_0000; D2 = 32'hA5A5_0002; D3 = 32'hA5A5_0003;

        // inputs of the cycle (v, sel, rdy, resp) | outputs expected in that cycle
        add(1, 2, 0, 0,  4'b0000, 0, 32'h0, 0, 0, 0, 0);   // reset state, grant q2
        add(1, 1, 1, 0,  4'b0100, 1, D2,    2, 0, 1, 0);   // SEND, grant ignored, handshake
        add(0, 0, 0, 0,  4'b0000, 0, D2,    2, 0, 1, 0);   // WAIT
        add(0, 0, 0, 1,  4'b0000, 0, D2,    2, 0, 1, 0);   // WAIT, response
        add(0, 0, 0, 0,  4'b0000, 0, D2,    2, 1, 1, 0);   // UPDATE
        add(0, 0, 0, 1,  4'b0000, 0, D2,    2, 0, 0, 0);   // IDLE, stray response
        add(1, 0, 0, 0,  4'b0000, 0, D2,    2, 0, 0, 0);   // IDLE, grant q0
        add(0, 0, 0, 1,  4'b0001, 1, D0,    0, 0, 1, 0);   // SEND 1, stray response
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 4'b0000, 1, D0, 0, 0, 1, 0);   // SEND 2..5 stalled
        add(0, 0, 1, 0,  4'b0000, 1, D0,    0, 0, 1, 0);   // SEND 6, handshake
        for (int i = 0; i < 8; i++)
            add(1, 3, 0, 0, 4'b0000, 0, D0, 0, 0, 1, 0);   // WAIT 8 cycles, no response
        add(0, 0, 0, 0,  4'b0000, 0, D0,    0, 1, 1, 1);   // UPDATE from timeout
        add(1, 3, 0, 0,  4'b0000, 0, D0,    0, 0, 0, 1);   // IDLE, grant q3
        add(0, 0, 1, 0,  4'b1000, 1, D3,    3, 0, 1, 1);   // SEND, handshake
        add(0, 0, 0, 1,  4'b0000, 0, D3,    3, 0, 1, 1);   // WAIT, response
        add(0, 0, 0, 0,  4'b0000, 0, D3,    3, 1, 1, 1);   // UPDATE, error stays sticky
        add(0, 0, 0, 0,  4'b0000, 0, D3,    3, 0, 0, 1);   // IDLE

        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            e = vq[i];
            check($sformatf("vec%0d pop", i),    64'(pop),           64'(e.pop));
            check($sformatf("vec%0d m_valid", i), 64'(m_valid),      64'(e.mv));
            check($sformatf("vec%0d m_data", i), 64'(m_data),        64'(e.data));
            check($sformatf("vec%0d m_id", i),   64'(m_id),          64'(e.id));
            check($sformatf("vec%0d update", i), 64'(update),        64'(e.upd));
            check($sformatf("vec%0d busy", i),   64'(busy),          64'(e.busy));
            check($sformatf("vec%0d timeout", i), 64'(timeout_error), 64'(e.to));
            valid = e.v; selection = e.sel; m_ready = e.rdy; resp_valid = e.resp;
            @(negedge clock);
        end

        // Back-to-back streaming: valid, m_ready and resp_valid held high.
        prev_upd = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("stream%0d pop", k), 64'(pop),
                  (k % 4 == 1) ? (64'd1 << sel_hist[k-1]) : 64'd0);
            check($sformatf("stream%0d update", k), 64'(update), 64'(k % 4 == 3));
            check($sformatf("stream%0d update_gap", k), 64'(prev_upd && update), 64'd0);
            prev_upd   = update;
            valid      = (k < 15);
            selection  = 2'((k >> 2) & 1);
            sel_hist[k] = selection;
            m_ready    = 1'b1;
            resp_valid = 1'b1;
            @(negedge clock);
        end
        check("stream_end busy", 64'(busy), 64'd0);

        // Reset in WAIT aborts the transaction without an update.
        valid = 1'b1; selection = 2'd1; m_ready = 1'b1; resp_valid = 1'b0;
        @(negedge clock);
        valid = 1'b0;
        @(negedge clock);
        check("abort pre busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1 check("abort outputs", {pop, m_valid, m_data, m_id, update, busy, timeout_error}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("abort idle%0d update", k), 64'(update), 64'd0);
            check($sformatf("abort idle%0d busy", k), 64'(busy), 64'd0);
            @(negedge clock);
        end
        valid = 1'b1; selection = 2'd1; m_ready = 1'b1;
        @(negedge clock);
        check("post pop", 64'(pop), 64'b0010);
        check("post m_data", 64'(m_data), 64'hA5A5_0001);
        check("post m_id", 64'(m_id), 64'd1);
        valid = 1'b0; resp_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clock);
            if (update) seen = 1'b1;
        end
        check("post update seen", 64'(seen), 64'd1);
        resp_valid = 1'b0; m_ready = 1'b0;
        @(negedge clock);

        // Out-of-range selection on a 3-queue instance is ignored.
        valid3 = 1'b1; selection3 = 2'd3;
        @(negedge clock);
        check("oor busy", 64'(busy3), 64'd0);
        check("oor pop", 64'(pop3), 64'd0);
        check("oor m_valid", 64'(m_valid3), 64'd0);
        selection3 = 2'd2;
        @(negedge clock);
        check("inr pop", 64'(pop3), 64'b100);
        check("inr m_data", 64'(m_data3), 64'h3C3C_0002);
        valid3 = 1'b0;
        repeat (6) @(negedge clock);
        check("inr done busy", 64'(busy3), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transaction_dispatcher.md
# transaction_dispatcher

Issuing end of the per-queue scheduling interface. Accepts the scheduler's `valid`/`selection` grant and pops the selected queue head. Forwards that transaction downstream over a valid/ready channel, waits for its completion, then returns the one-cycle `update` pulse that the scheduler's budget regulation consumes. Exactly one transaction is outstanding at a time.

## Interface
- `NUMBER_OF_QUEUES`, 4, number of request queues / scheduler inputs
- `DATA_WIDTH`, 32, transaction payload width
- `TIMEOUT_CYCLES`, 255, max cycles waited for completion, ≥1, fits in 16 bits
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `valid`  in  1  scheduler grant valid
- `selection`  in  $clog2(NUMBER_OF_QUEUES)  granted queue index
- `queue_heads`  in  [NUMBER_OF_QUEUES][DATA_WIDTH]  head entry of each queue
- `pop`  out  NUMBER_OF_QUEUES  one-hot, one-cycle dequeue strobe
- `m_valid`  out  1  downstream request valid
- `m_ready`  in  1  downstream request ready
- `m_data`  out  DATA_WIDTH  request payload
- `m_id`  out  $clog2(NUMBER_OF_QUEUES)  originating queue index
- `resp_valid`  in  1  completion of the outstanding request
- `update`  out  1  one-cycle completion pulse to the scheduler
- `busy`  out  1  high in every state except IDLE
- `timeout_error`  out  1  sticky, set on completion timeout

## Operation
- FSM states: IDLE, SEND, WAIT, UPDATE.
- IDLE: if `valid` and `selection < NUMBER_OF_QUEUES`, then at that edge:
  - latch `selection` into `m_id`
  - latch `queue_heads[selection]` into `m_data`
  - go to SEND.
- IDLE with an out-of-range `selection`: ignore the grant and stay in IDLE.
- SEND:
  - `m_valid`=1.
  - `pop[m_id]`=1 in the first SEND cycle only.
  - `m_data`/`m_id` stay stable until the handshake.
  - On `m_valid & m_ready`, go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On `resp_valid`, go to UPDATE.
  - When the counter reaches `TIMEOUT_CYCLES` without `resp_valid`, set `timeout_error` and go to UPDATE.
- UPDATE: `update`=1 for exactly one cycle, then go to IDLE.
- `valid` is ignored in SEND, WAIT and UPDATE. `resp_valid` is ignored outside WAIT.
- `resp_valid` on the same cycle as a timeout is treated as a response: `timeout_error` is not set.
- `timeout_error` clears only on `reset`.
- Counter is 16-bit and cannot wrap: it stops at `TIMEOUT_CYCLES`.

## Timing
- Reset values: state IDLE, `pop`=0, `m_valid`=0, `m_data`=0, `m_id`=0, `update`=0, `busy`=0, `timeout_error`=0, counter 0.
- Reset asserted mid-transaction aborts it immediately (asynchronously). No `update` is emitted for the aborted transaction.
- All outputs are registered or decoded from state only; no combinational input→output path.
- Grant sampled at edge t: `pop` and `m_valid` are high in cycle t+1.
- `m_ready` high in cycle t+1: state is WAIT in t+2.
- `resp_valid` sampled at edge r: `update` is high in cycle r+1 and low in r+2.
- Earliest next grant is sampled at edge r+2.
  - So `update` is always low for ≥1 cycle between pulses, which gives the scheduler a clean rising edge.
- Minimum grant-to-grant period: 4 cycles (accept, SEND, WAIT with immediate response, UPDATE).

## Test plan
- Reset, then `valid`=1, `selection`=2, `queue_heads[2]`=0xA5A5_0002, `m_ready`=1, `resp_valid` one cycle after the handshake. Required:
  - `pop`=4'b0100 for one cycle
  - `m_data`=0xA5A5_0002, `m_id`=2
  - `update` pulses one cycle, 4 cycles after the grant edge.
- `m_ready` held low 5 cycles. Required: `m_valid` high all 6 SEND cycles with constant `m_data`/`m_id`; `pop` high only in the first.
- `TIMEOUT_CYCLES`=8, no `resp_valid`. Required: `timeout_error` rises and `update` pulses 8 cycles after the handshake; `timeout_error` stays 1 for the subsequent transactions.
- `valid` held high continuously with alternating `selection` 0/1 and zero-latency `m_ready`/`resp_valid`. Required:
  - one `pop` per 4 cycles
  - `update` never high on two consecutive cycles
  - grants during busy are ignored.
- `resp_valid` pulsed in IDLE and SEND. Required: no `update`, FSM unaffected.
- `reset` asserted in WAIT. Required: immediate return to IDLE, all outputs 0, no `update`; the next grant proceeds normally.
